pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage 16-bit pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, taken branches resolved in MEM, and slow data-memory accesses.
- Generates PC/IF-ID write enables, per-stage flushes, a global hold and the PC source select.
- Holds a small state machine, a memory-wait timeout counter and saturating event counters.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline: hazard FSM encodings, register
// address width and the control-field bubble pattern loaded by flushed stages.
package pipe_pkg;

    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_ILLEGAL    = 2'd3
    } state_t;

    // Control fields carried by ID/EX and EX/MEM; a flush loads CTRL_BUBBLE.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational hazard terms: load-use against the ID operands, branch taken
// in MEM, and a data-memory access that has not completed this cycle.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int RAW = REG_AW
) (
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic           id_uses_rt,
    input  logic           ex_mem_read,
    input  logic [RAW-1:0] ex_rd,
    input  logic           mem_branch,
    input  logic           mem_zero,
    input  logic           mem_access,
    input  logic           mem_ready,
    output logic           load_use,
    output logic           taken,
    output logic           mem_busy
);

    // R0 is hardwired to zero, so a load targeting it can never feed a consumer.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign taken    = mem_branch & mem_zero;
    assign mem_busy = mem_access & ~mem_ready;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush/hold decode, memory-wait timeout and
// saturating stall/flush event counters.
//
// state         | meaning
// ST_RUN        | normal issue, all hazards evaluated
// ST_LOAD_STALL | one bubble cycle after a load-use stall, load_use masked
// ST_MEM_WAIT   | whole pipe held until mem_ready or timeout
// ST_ILLEGAL    | unreachable, decodes as RUN and recovers next cycle
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = pipe_pkg::REG_AW,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_branch,
    input  logic              mem_zero,
    input  logic              mem_access,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              pipe_hold,
    output logic              pc_src,
    output logic              mem_error,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
    output logic [1:0]        state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W:0] TIMEOUT_LIM = (WAIT_W + 1)'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic              load_use, taken, mem_busy;
    logic              stall_inc, flush_inc, err_set;
    logic [WAIT_W:0]   wait_plus;

    hazard_detect #(.RAW(REG_AW)) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .mem_branch  (mem_branch),
        .mem_zero    (mem_zero),
        .mem_access  (mem_access),
        .mem_ready   (mem_ready),
        .load_use    (load_use),
        .taken       (taken),
        .mem_busy    (mem_busy)
    );

    assign wait_plus = {1'b0, wait_cnt} + (WAIT_W + 1)'(1);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_hold    = 1'b0;
        pc_src       = 1'b0;
        state_d      = ST_RUN;
        wait_d       = '0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        err_set      = 1'b0;

        case (state_q)
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    pipe_hold   = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    // The cycle whose increment reaches the limit is the last held one.
                    if (wait_plus >= TIMEOUT_LIM) begin
                        err_set = 1'b1;
                    end else begin
                        state_d = ST_MEM_WAIT;
                        wait_d  = (wait_cnt == '1) ? wait_cnt : wait_plus[WAIT_W-1:0];
                    end
                end
            end
            ST_RUN, ST_LOAD_STALL: begin
                if (mem_busy) begin
                    pipe_hold   = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    state_d     = ST_MEM_WAIT;
                    wait_d      = WAIT_W'(1);
                end else if (taken) begin
                    pc_src       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    flush_inc    = 1'b1;
                end else if (load_use && state_q == ST_RUN) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                    state_d     = ST_LOAD_STALL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt    <= '0;
            mem_error   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
            if (err_set)
                mem_error <= 1'b1;
            if (stall_inc && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (flush_inc && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle decode table from RUN
// plus sequences for load stall, memory wait, timeout, reset and saturation.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_mem_read, mem_branch, mem_zero, mem_access, mem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, pc_src;
    logic        mem_error;
    logic [15:0] stall_count, flush_count;
    logic [1:0]  state;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
    logic        s_pipe_hold, s_pc_src, s_mem_error;
    logic [3:0]  s_stall_count, s_flush_count;
    logic [1:0]  s_state;

    logic [6:0]  outs;
    int          applied = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_access(mem_access), .mem_ready(mem_ready), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pipe_hold(pipe_hold), .pc_src(pc_src),
        .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count),
        .state(state)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    pipeline_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_access(mem_access), .mem_ready(mem_ready), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .pipe_hold(s_pipe_hold), .pc_src(s_pc_src),
        .mem_error(s_mem_error), .stall_count(s_stall_count), .flush_count(s_flush_count),
        .state(s_state)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, pc_src}
    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, pc_src};

    localparam logic [6:0] O_DEF   = 7'b1100000;
    localparam logic [6:0] O_STALL = 7'b0001000;
    localparam logic [6:0] O_TAKEN = 7'b1111101;
    localparam logic [6:0] O_HOLD  = 7'b0000010;

    typedef struct {
        string       name;
        logic [2:0]  rs, rt;
        logic        uses_rt, mrd;
        logic [2:0]  exrd;
        logic        br, z, acc, rdy;
        logic [6:0]  exp_out;
        logic [1:0]  exp_st;
        logic [15:0] exp_stall, exp_flush;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [2:0] rs, input logic [2:0] rt, input logic uses_rt,
                          input logic mrd, input logic [2:0] exrd, input logic br,
                          input logic z, input logic acc, input logic rdy);
        id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; ex_mem_read = mrd; ex_rd = exrd;
        mem_branch = br; mem_zero = z; mem_access = acc; mem_ready = rdy;
    endtask

    task automatic idle();
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        //                name          rs    rt    ur    mrd   exrd  br    z     acc   rdy   out      st    stall  flush
        vecs[0] = '{"idle",        3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF,   2'd0, 16'd0, 16'd0};
        vecs[1] = '{"lu_rs",       3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL, 2'd1, 16'd1, 16'd0};
        vecs[2] = '{"lu_r0",       3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF,   2'd0, 16'd0, 16'd0};
        vecs[3] = '{"lu_rt",       3'd1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL, 2'd1, 16'd1, 16'd0};
        vecs[4] = '{"rt_unused",   3'd1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF,   2'd0, 16'd0, 16'd0};
        vecs[5] = '{"no_load",     3'd3, 3'd3, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF,   2'd0, 16'd0, 16'd0};
        vecs[6] = '{"taken_lu",    3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, O_TAKEN, 2'd0, 16'd0, 16'd1};
        vecs[7] = '{"not_taken",   3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, O_DEF,   2'd0, 16'd0, 16'd0};
        vecs[8] = '{"busy_taken",  3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, O_HOLD,  2'd2, 16'd0, 16'd0};
        vecs[9] = '{"ready_lu",    3'd4, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, O_STALL, 2'd1, 16'd1, 16'd0};

        do_reset();
        chk("reset_outs", 32'(outs), 32'(O_DEF));
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_stall", 32'(stall_count), 32'd0);
        chk("reset_flush", 32'(flush_count), 32'd0);
        chk("reset_err", 32'(mem_error), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mrd, vecs[i].exrd,
                   vecs[i].br, vecs[i].z, vecs[i].acc, vecs[i].rdy);
            #1;
            chk({vecs[i].name, "_outs"}, 32'(outs), 32'(vecs[i].exp_out));
            step();
            chk({vecs[i].name, "_state"}, 32'(state), 32'(vecs[i].exp_st));
            chk({vecs[i].name, "_stall"}, 32'(stall_count), 32'(vecs[i].exp_stall));
            chk({vecs[i].name, "_flush"}, 32'(flush_count), 32'(vecs[i].exp_flush));
        end

        // Load stall lasts one cycle even with the hazard still present.
        do_reset();
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("ls_state", 32'(state), 32'd1);
        chk("ls_outs_masked", 32'(outs), 32'(O_DEF));
        step();
        chk("ls_back_run", 32'(state), 32'd0);
        chk("ls_stall_cnt", 32'(stall_count), 32'd1);

        // Taken branch during the stall cycle is still honoured.
        idle();
        do_reset();
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("ls_taken_outs", 32'(outs), 32'(O_TAKEN));
        step();
        chk("ls_taken_flush", 32'(flush_count), 32'd1);
        chk("ls_taken_state", 32'(state), 32'd0);

        // Memory wait: three held cycles, then ready.
        idle();
        do_reset();
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("mw_hold%0d", c), 32'(outs), 32'(O_HOLD));
            step();
            chk($sformatf("mw_state%0d", c), 32'(state), 32'd2);
        end
        mem_ready = 1'b1;
        #1;
        chk("mw_ready_outs", 32'(outs), 32'(O_DEF));
        step();
        chk("mw_ready_state", 32'(state), 32'd0);
        chk("mw_no_err", 32'(mem_error), 32'd0);

        // Timeout: 15 held cycles then mem_error, sticky.
        idle();
        do_reset();
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 14; c++) step();
        chk("to_pre_state", 32'(state), 32'd2);
        chk("to_pre_err", 32'(mem_error), 32'd0);
        chk("to_pre_hold", 32'(pipe_hold), 32'd1);
        step();
        chk("to_err", 32'(mem_error), 32'd1);
        chk("to_state_run", 32'(state), 32'd0);
        for (int c = 0; c < 5; c++) step();
        chk("to_err_sticky", 32'(mem_error), 32'd1);

        // Async reset mid-wait.
        step();
        chk("rstw_in_wait", 32'(state), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_state", 32'(state), 32'd0);
        chk("rstw_err", 32'(mem_error), 32'd0);
        rst = 1'b0;
        idle();
        #1;

        // Saturation: 20 stalls on a 4-bit counter pin at 15; 16-bit counter reads 20.
        do_reset();
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) step();
        chk("sat_stall_narrow", 32'(s_stall_count), 32'hF);
        chk("sat_stall_wide", 32'(stall_count), 32'd20);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
